// File: rtl/mapu_ctrl_fsm.sv
// Matrix APU control FSM: accepts one command, walks the element-index beats
// for the datapath, waits out the drain latency and reports completion.
//
// Ports:
//   clk, reset (async, active-high)
//   cmd_valid/cmd_ready/cmd_op/cmd_dim          command handshake
//   elem_valid/elem_ready/elem_row/col/k        element beat stream
//   elem_first/elem_last                        k-run boundaries of an element
//   done/err                                    one-cycle status pulses
//   err_clr                                     leaves the ERR state
//   locked/state/op_count                       probe and statistics outputs
module mapu_ctrl_fsm #(
    parameter int MAX_DIM      = 8,
    parameter int DIM_W        = 4,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [DIM_W-1:0] cmd_dim,
    output logic             elem_valid,
    input  logic             elem_ready,
    output logic [DIM_W-1:0] elem_row,
    output logic [DIM_W-1:0] elem_col,
    output logic [DIM_W-1:0] elem_k,
    output logic             elem_first,
    output logic             elem_last,
    output logic             done,
    output logic             err,
    input  logic             err_clr,
    output logic             locked,
    output logic [7:0]       state,
    output logic [15:0]      op_count
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_ILL = 2'd3;

    typedef enum logic [7:0] {
        S_IDLE  = 8'h00,
        S_EXEC  = 8'h02,
        S_DRAIN = 8'h03,
        S_ERR   = 8'hFF
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [DIM_W-1:0]   dim_q, dim_d;
    logic [DIM_W-1:0]   row_q, row_d;
    logic [DIM_W-1:0]   col_q, col_d;
    logic [DIM_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               elem_valid_q, elem_valid_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               locked_q, locked_d;
    logic [15:0]        op_count_q, op_count_d;

    logic               illegal;
    logic               hs;
    logic [DIM_W-1:0]   dim_m1;
    logic [DIM_W-1:0]   dim_d_m1;
    logic               k_end;
    logic               col_end;
    logic               row_end;

    assign illegal  = (cmd_op == OP_ILL) ||
                      (cmd_dim == '0) ||
                      (cmd_dim > DIM_W'(MAX_DIM));
    assign hs       = elem_valid_q && elem_ready;
    assign dim_m1   = dim_q - DIM_W'(1);
    assign dim_d_m1 = dim_d - DIM_W'(1);
    // Non-MUL ops hold k at 0, so every beat closes its k-run.
    assign k_end    = (op_q != OP_MUL) || (k_q == dim_m1);
    assign col_end  = (col_q == dim_m1);
    assign row_end  = (row_q == dim_m1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            dim_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            k_q          <= '0;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b1;
            elem_valid_q <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            locked_q     <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            dim_q        <= dim_d;
            row_q        <= row_d;
            col_q        <= col_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            elem_valid_q <= elem_valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
            done_q       <= done_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
            op_count_q   <= op_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dim_d      = dim_q;
        row_d      = row_q;
        col_d      = col_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        op_count_d = op_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (illegal) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                        op_d    = cmd_op;
                        dim_d   = cmd_dim;
                        row_d   = '0;
                        col_d   = '0;
                        k_d     = '0;
                    end
                end
            end
            S_EXEC: begin
                if (hs) begin
                    if (k_end) begin
                        k_d = '0;
                        if (col_end) begin
                            col_d = '0;
                            if (row_end) begin
                                row_d   = '0;
                                state_d = S_DRAIN;
                                cnt_d   = CNT_W'(DRAIN_CYCLES);
                            end else begin
                                row_d = row_q + DIM_W'(1);
                            end
                        end else begin
                            col_d = col_q + DIM_W'(1);
                        end
                    end else begin
                        k_d = k_q + DIM_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Count value 1 marks the final drain cycle.
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    op_count_d = op_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output flags are derived from the next state so they leave flops.
        cmd_ready_d  = (state_d == S_IDLE);
        elem_valid_d = (state_d == S_EXEC);
        locked_d     = (state_d == S_EXEC) || (state_d == S_DRAIN);
        first_d      = elem_valid_d && (k_d == '0);
        last_d       = elem_valid_d &&
                       ((op_d != OP_MUL) || (k_d == dim_d_m1));
    end

    assign cmd_ready  = cmd_ready_q;
    assign elem_valid = elem_valid_q;
    assign elem_row   = row_q;
    assign elem_col   = col_q;
    assign elem_k     = k_q;
    assign elem_first = first_q;
    assign elem_last  = last_q;
    assign done       = done_q;
    assign err        = err_q;
    assign locked     = locked_q;
    assign state      = state_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_mapu_ctrl_fsm.sv
// Self-checking bench for mapu_ctrl_fsm: randomized commands and backpressure
// compared against a beat-list and cycle-timing model of the command flow.
module tb_mapu_ctrl_fsm;

    localparam int MAX_DIM = 8;
    localparam int DIM_W   = 4;
    localparam int DRAIN   = 4;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [DIM_W-1:0] cmd_dim;
    logic             elem_valid;
    logic             elem_ready;
    logic [DIM_W-1:0] elem_row;
    logic [DIM_W-1:0] elem_col;
    logic [DIM_W-1:0] elem_k;
    logic             elem_first;
    logic             elem_last;
    logic             done;
    logic             err;
    logic             err_clr;
    logic             locked;
    logic [7:0]       state;
    logic [15:0]      op_count;

    mapu_ctrl_fsm #(
        .MAX_DIM(MAX_DIM),
        .DIM_W(DIM_W),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_dim(cmd_dim),
        .elem_valid(elem_valid),
        .elem_ready(elem_ready),
        .elem_row(elem_row),
        .elem_col(elem_col),
        .elem_k(elem_k),
        .elem_first(elem_first),
        .elem_last(elem_last),
        .done(done),
        .err(err),
        .err_clr(err_clr),
        .locked(locked),
        .state(state),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_ops = '0;

    typedef struct packed {
        logic [DIM_W-1:0] r;
        logic [DIM_W-1:0] c;
        logic [DIM_W-1:0] k;
        logic             f;
        logic             l;
    } beat_t;

    beat_t exp_q[$];

    // Expected beat list: row outer, col middle, k inner (k only for MUL).
    function automatic void build(input int op, input int n);
        int kmax;
        beat_t b;
        exp_q.delete();
        kmax = (op == 1) ? n : 1;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int k = 0; k < kmax; k++) begin
                    b.r = DIM_W'(r);
                    b.c = DIM_W'(c);
                    b.k = DIM_W'(k);
                    b.f = (k == 0);
                    b.l = (k == kmax - 1);
                    exp_q.push_back(b);
                end
    endfunction

    // Offer a command once cmd_ready is seen; it is taken at the next edge.
    task automatic issue(input logic [1:0] op, input int dim);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL issue_wait cmd_ready=%b required=1", cmd_ready);
        end
        cmd_op    = op;
        cmd_dim   = DIM_W'(dim);
        cmd_valid = 1'b1;
    endtask

    // Follows one accepted command to its done pulse.
    // mode 0: ready always, 1: ready on odd cycles, 2: random ready.
    task automatic track(input int op, input int dim, input int mode,
                         input bit hold, input logic [1:0] nop,
                         input int ndim, input int exp_done_t);
        int t = 0;
        int last_hs = -1;
        int bound;
        bit seen = 0;
        bit rdy;
        beat_t b;
        logic [7:0] es;
        build(op, dim);
        bound = exp_q.size() * 4 + DRAIN + 20;
        while (!seen && t < bound) begin
            @(negedge clk);
            t++;
            if (t == 1) begin
                if (hold) begin
                    cmd_op  = nop;
                    cmd_dim = DIM_W'(ndim);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (done === 1'b1) begin
                seen = 1;
                exp_ops = exp_ops + 16'd1;
                checks += 6;
                if (t != last_hs + DRAIN + 1) begin
                    failures++;
                    $display("FAIL done_time t=%0d required=%0d", t, last_hs + DRAIN + 1);
                end
                if (exp_done_t > 0 && t != exp_done_t) begin
                    failures++;
                    $display("FAIL done_abs t=%0d required=%0d", t, exp_done_t);
                end
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL beats_left got=%0d required=0", exp_q.size());
                end
                if (state !== 8'h00 || cmd_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL done_idle state=%h rdy=%b required=00/1", state, cmd_ready);
                end
                if (locked !== 1'b0 || elem_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL done_lock locked=%b ev=%b required=0/0", locked, elem_valid);
                end
                if (op_count !== exp_ops) begin
                    failures++;
                    $display("FAIL op_count got=%0d required=%0d", op_count, exp_ops);
                end
            end else begin
                es = (exp_q.size() > 0) ? 8'h02 : 8'h03;
                checks += 3;
                if (state !== es) begin
                    failures++;
                    $display("FAIL busy_state t=%0d got=%h required=%h", t, state, es);
                end
                if (locked !== 1'b1 || cmd_ready !== 1'b0 || err !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_flags t=%0d lk=%b rdy=%b err=%b required=1/0/0",
                             t, locked, cmd_ready, err);
                end
                if (elem_valid !== (exp_q.size() > 0)) begin
                    failures++;
                    $display("FAIL elem_valid t=%0d got=%b required=%b",
                             t, elem_valid, exp_q.size() > 0);
                end
                if (exp_q.size() > 0) begin
                    b = exp_q[0];
                    checks++;
                    if (elem_row !== b.r || elem_col !== b.c || elem_k !== b.k ||
                        elem_first !== b.f || elem_last !== b.l) begin
                        failures++;
                        $display("FAIL beat t=%0d got=(%0d,%0d,%0d,f%b,l%b) required=(%0d,%0d,%0d,f%b,l%b)",
                                 t, elem_row, elem_col, elem_k, elem_first, elem_last,
                                 b.r, b.c, b.k, b.f, b.l);
                    end
                    case (mode)
                        0: rdy = 1'b1;
                        1: rdy = (t % 2 == 1);
                        default: rdy = 1'($urandom_range(0, 1));
                    endcase
                    elem_ready = rdy;
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        last_hs = t;
                    end
                end
                err_clr = 1'($urandom_range(0, 1));
            end
        end
        err_clr = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout op=%0d dim=%0d", op, dim);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (state !== 8'h00 || cmd_ready !== 1'b1 || op_count !== 16'd0 ||
            elem_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            locked !== 1'b0 || elem_first !== 1'b0 || elem_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_vals state=%h rdy=%b cnt=%0d ev=%b required=00/1/0/0",
                     state, cmd_ready, op_count, elem_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_ops = '0;
    endtask

    task automatic test_add();
        issue(2'd0, 2);
        track(0, 2, 0, 0, 2'd0, 0, 9);
    endtask

    task automatic test_mul_backpressure();
        issue(2'd1, 2);
        track(1, 2, 1, 0, 2'd0, 0, 0);
    endtask

    task automatic test_illegal();
        logic [1:0] ops[3];
        int dims[3];
        int n;
        ops[0] = 2'd3; dims[0] = 2;
        ops[1] = 2'd0; dims[1] = 0;
        ops[2] = 2'd1; dims[2] = 9;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], dims[i]);
            @(negedge clk);
            cmd_valid = 1'b0;
            checks += 2;
            if (state !== 8'hFF || err !== 1'b1) begin
                failures++;
                $display("FAIL ill_enter i=%0d state=%h err=%b required=ff/1", i, state, err);
            end
            if (cmd_ready !== 1'b0 || locked !== 1'b0 || elem_valid !== 1'b0) begin
                failures++;
                $display("FAIL ill_flags i=%0d rdy=%b lk=%b ev=%b required=0/0/0",
                         i, cmd_ready, locked, elem_valid);
            end
            n = $urandom_range(1, 3);
            cmd_op    = 2'd0;
            cmd_dim   = DIM_W'(2);
            cmd_valid = 1'b1;
            for (int j = 0; j < n; j++) begin
                @(negedge clk);
                checks++;
                if (state !== 8'hFF || err !== 1'b0) begin
                    failures++;
                    $display("FAIL ill_hold i=%0d state=%h err=%b required=ff/0", i, state, err);
                end
            end
            cmd_valid = 1'b0;
            err_clr   = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            checks++;
            if (state !== 8'h00 || cmd_ready !== 1'b1 || op_count !== exp_ops) begin
                failures++;
                $display("FAIL ill_clear i=%0d state=%h rdy=%b cnt=%0d required=00/1/%0d",
                         i, state, cmd_ready, op_count, exp_ops);
            end
        end
    endtask

    task automatic test_back_to_back();
        issue(2'd2, 1);
        track(2, 1, 0, 1, 2'd1, 2, 1 + DRAIN + 1);
        track(1, 2, 2, 0, 2'd0, 0, 0);
    endtask

    task automatic test_random();
        int op;
        int dim;
        for (int i = 0; i < 6; i++) begin
            op  = $urandom_range(0, 2);
            dim = $urandom_range(1, 4);
            issue(2'(op), dim);
            track(op, dim, 2, 0, 2'd0, 0, 0);
        end
    endtask

    task automatic test_abort();
        issue(2'd1, 8);
        @(negedge clk);
        cmd_valid  = 1'b0;
        elem_ready = 1'b1;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (state !== 8'h00 || cmd_ready !== 1'b1 || elem_valid !== 1'b0 ||
            locked !== 1'b0 || done !== 1'b0 || op_count !== 16'd0) begin
            failures++;
            $display("FAIL abort_vals state=%h rdy=%b ev=%b lk=%b cnt=%0d required=00/1/0/0/0",
                     state, cmd_ready, elem_valid, locked, op_count);
        end
        exp_ops = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DRAIN + 4; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || state !== 8'h00) begin
                failures++;
                $display("FAIL abort_quiet done=%b state=%h required=0/00", done, state);
            end
        end
        issue(2'd1, 2);
        track(1, 2, 2, 0, 2'd0, 0, 0);
    endtask

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_dim    = '0;
        elem_ready = 1'b1;
        err_clr    = 1'b0;
        test_reset();
        test_add();
        test_mul_backpressure();
        test_illegal();
        test_back_to_back();
        test_random();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mapu_ctrl_fsm.md
# mapu_ctrl_fsm

Control state machine of the Matrix APU. It accepts one matrix command at a time over a valid/ready handshake and sequences the element-index beats for the datapath. It then waits a fixed drain latency and signals completion. It also drives the probe signals `locked` and `state[7:0]` that the environment's MAPU probe interface samples.

## Interface
Parameters:
- `MAX_DIM`, default 8: largest legal matrix dimension.
- `DIM_W`, default 4: width of the dimension and index fields. Must satisfy 2^DIM_W > MAX_DIM.
- `DRAIN_CYCLES`, default 4: datapath flush latency after the last beat. Must be at least 1.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FSM can accept a command.
- `cmd_op`  in  2  opcode: 0 = ADD, 1 = MUL, 2 = TRANSPOSE, 3 = reserved/illegal.
- `cmd_dim`  in  DIM_W  matrix dimension N.
- `elem_valid`  out  1  element beat offered to the datapath.
- `elem_ready`  in  1  datapath accepts the beat.
- `elem_row`, `elem_col`, `elem_k`  out  DIM_W each  beat indices.
- `elem_first` / `elem_last`  out  1 each  first / last k-beat of the current output element.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse on illegal command.
- `err_clr`  in  1  leave the ERR state.
- `locked`  out  1  a command is in flight.
- `state`  out  8  state code for the probe.
- `op_count`  out  16  number of completed commands.

## Operation
- State codes: IDLE = 0x00, EXEC = 0x02, DRAIN = 0x03, ERR = 0xFF. All other codes are unused.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid`: the command is illegal if `cmd_op` == 3, `cmd_dim` == 0, or `cmd_dim` > MAX_DIM. An illegal command moves the FSM to ERR. A legal command latches op and dim, clears row/col/k to 0, and moves to EXEC.
- **EXEC**
  - `elem_valid` = 1. Indices advance only on the handshake `elem_valid && elem_ready`.
  - Iteration order: row is the outer loop, col the middle, k the inner.
  - MUL iterates k over 0..N-1, giving N^3 beats.
  - ADD and TRANSPOSE hold k = 0, giving N^2 beats. For these ops `elem_first` = `elem_last` = 1 on every beat.
  - For MUL, `elem_first` = (k == 0) and `elem_last` = (k == N-1).
  - The handshake on the final beat (row = col = N-1, k = last) moves the FSM to DRAIN.
- **DRAIN**
  - The counter loads DRAIN_CYCLES on entry and decrements each cycle.
  - When it expires the FSM moves to IDLE. `done` pulses and `op_count` increments (16-bit, wraps 0xFFFF to 0x0000) in the first IDLE cycle.
- **ERR**
  - `err` pulses in the first ERR cycle.
  - The FSM stays in ERR until `err_clr` = 1, then moves to IDLE on the next edge.
  - `err_clr` is ignored in all other states.
  - Illegal commands do not change `op_count`.
- `locked` = 1 when state is EXEC or DRAIN, 0 in IDLE and ERR.
- The command inputs are ignored outside IDLE; `cmd_ready` = 0 in those states.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready` = 1 and `state` = 0x00; every other output is 0.
- Reset mid-operation aborts immediately to those values. The aborted command is not counted and produces no `done`.
- Command accepted at edge T: state = EXEC and `elem_valid` = 1 from cycle T+1.
- Backpressure: while `elem_valid && !elem_ready`, all indices and flags hold stable.
- Last beat handshake at cycle L: DRAIN occupies L+1 .. L+DRAIN_CYCLES. `done` = 1, state = IDLE and `cmd_ready` = 1 at L+DRAIN_CYCLES+1.
- Back-to-back commands: a command offered in the `done` cycle is accepted in that cycle.
- Command latency with no backpressure = beats + DRAIN_CYCLES + 1 cycles from the accept edge to `done`.
- Illegal command accepted at T: state = 0xFF and `err` = 1 at T+1. `err_clr` sampled at cycle E gives IDLE at E+1.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → all outputs take their reset values immediately (`state` = 0x00, `cmd_ready` = 1, `op_count` = 0).
- **ADD, N=2:** `elem_ready` held at 1, command accepted at cycle 0 → beats at cycles 1-4 with (row,col) = (0,0), (0,1), (1,0), (1,1); `done` at cycle 9; `locked` high for cycles 1-8; `op_count` = 1.
- **MUL, N=2 with backpressure:** `elem_ready` toggling 1,0 → 8 beats in (r,c,k) order (0,0,0) … (1,1,1); `elem_last` set on odd k; indices stable during stalls.
- **Illegal commands:** op=3, then dim=0, then dim=9 → each enters state 0xFF with a single `err` pulse; `err_clr` returns the FSM to IDLE; `op_count` unchanged.
- **Back-to-back:** TRANSPOSE N=1 with a second command held on `cmd_valid` → the second command is accepted in the `done` cycle of the first, with no idle gap.
- **Abort:** reset asserted during EXEC of a MUL N=8 → no `done`; the next command runs normally from (0,0,0).
